// File: rtl/fp_pkg.sv
// Shared floating-point helpers: rounding-mode encodings and field extraction
// parametrised at call time by exponent/mantissa width (formats up to 64 bits).
package fp_pkg;

  localparam logic [1:0] RND_TRUNC = 2'b00;
  localparam logic [1:0] RND_FLOOR = 2'b01;
  localparam logic [1:0] RND_CEIL  = 2'b10;
  localparam logic [1:0] RND_RNE   = 2'b11;

  function automatic int unsigned fp_bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 32'd1;
  endfunction

  function automatic logic fp_sign(input logic [63:0] x, input int unsigned exp_w,
                                   input int unsigned man_w);
    logic [63:0] t;
    t = x >> (exp_w + man_w);
    return t[0];
  endfunction

  function automatic logic [63:0] fp_exp(input logic [63:0] x, input int unsigned exp_w,
                                         input int unsigned man_w);
    return (x >> man_w) & ((64'd1 << exp_w) - 64'd1);
  endfunction

  function automatic logic [63:0] fp_man(input logic [63:0] x, input int unsigned man_w);
    return x & ((64'd1 << man_w) - 64'd1);
  endfunction

endpackage

// File: rtl/fp_round_pipe_if.sv
// Streaming valid/ready bundle for fp_round_pipe.
// out_inexact exists only when FP_ROUND_INEXACT_EN is defined.
interface fp_round_pipe_if #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
);
  logic                   in_valid;
  logic                   in_ready;
  logic [EXP_W+MAN_W:0]   in_data;
  logic [1:0]             in_mode;
  logic                   out_valid;
  logic                   out_ready;
  logic [EXP_W+MAN_W:0]   out_data;
`ifdef FP_ROUND_INEXACT_EN
  logic                   out_inexact;
`endif

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data
`ifdef FP_ROUND_INEXACT_EN
    , input out_inexact
`endif
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data
`ifdef FP_ROUND_INEXACT_EN
    , output out_inexact
`endif
  );

endinterface

// File: rtl/fp_round_core.sv
// Combinational classify / increment decision for round-to-integral.
// Produces sign, truncated magnitude and an addend so the next stage only adds.
module fp_round_core
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0]   data_i,
  input  logic [1:0]             mode_i,
  output logic                   sign_o,
  output logic [EXP_W+MAN_W-1:0] mag_o,
  output logic [EXP_W+MAN_W-1:0] addend_o
`ifdef FP_ROUND_INEXACT_EN
  , output logic                 inexact_o
`endif
);

  localparam int BIAS = int'(fp_bias(EXP_W));

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;
  logic [MAN_W-1:0] mask;
  logic [MAN_W-1:0] half_mask;
  logic             sign;
  logic             frac_nz, half, sticky, lsb, inc, one;
  int               e;

  assign sign  = fp_sign(64'(data_i), EXP_W, MAN_W);
  assign exp_f = EXP_W'(fp_exp(64'(data_i), EXP_W, MAN_W));
  assign man_f = MAN_W'(fp_man(64'(data_i), MAN_W));
  assign e     = int'(exp_f) - BIAS;

  // Fraction bits are the low MAN_W-e mantissa bits; half_mask isolates the top one.
  assign mask      = {MAN_W{1'b1}} >> e;
  assign half_mask = mask & ~(mask >> 1);
  assign frac_nz   = |(man_f & mask);
  assign half      = |(man_f & half_mask);
  assign sticky    = |(man_f & (mask >> 1));
  assign lsb       = (e == 0) | (|(man_f & (half_mask << 1)));

  always_comb begin
    sign_o   = sign;
    mag_o    = data_i[EXP_W+MAN_W-1:0];
    addend_o = '0;
    inc      = 1'b0;
    one      = 1'b0;
`ifdef FP_ROUND_INEXACT_EN
    inexact_o = 1'b0;
`endif
    if ((&exp_f) || (exp_f == '0 && man_f == '0) || e >= int'(MAN_W)) begin
      // Inf/NaN, zero and already-integral values pass through untouched.
    end else if (e < 0) begin
      case (mode_i)
        RND_TRUNC: one = 1'b0;
        RND_FLOOR: one = sign;
        RND_CEIL:  one = ~sign;
        default:   one = (e == -1) && (man_f != '0);
      endcase
      mag_o = one ? {EXP_W'(BIAS), {MAN_W{1'b0}}} : '0;
`ifdef FP_ROUND_INEXACT_EN
      inexact_o = 1'b1;
`endif
    end else begin
      case (mode_i)
        RND_TRUNC: inc = 1'b0;
        RND_FLOOR: inc = sign & frac_nz;
        RND_CEIL:  inc = ~sign & frac_nz;
        default:   inc = half & (sticky | lsb);
      endcase
      mag_o    = {exp_f, man_f & ~mask};
      // One unit in the last integral place; at e == 0 this lands on the exponent LSB.
      addend_o = inc ? {{(EXP_W-1){1'b0}}, half_mask, 1'b0} : '0;
`ifdef FP_ROUND_INEXACT_EN
      inexact_o = frac_nz;
`endif
    end
  end

endmodule

// File: rtl/fp_round_pipe.sv
// Two-stage pipelined FP round-to-integral with valid/ready backpressure.
// Define FP_ROUND_INEXACT_EN to build the out_inexact flag.
module fp_round_pipe
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input logic            clk,
  input logic            rst,
  fp_round_pipe_if.slave bus
);

  localparam int unsigned MW = EXP_W + MAN_W;

  logic          adv;
  logic          c_sign;
  logic [MW-1:0] c_mag, c_add;

  logic          s1_valid_q, s1_sign_q;
  logic [MW-1:0] s1_mag_q, s1_add_q;
  logic          out_valid_q;
  logic [MW:0]   out_data_q, out_data_d;

`ifdef FP_ROUND_INEXACT_EN
  logic c_inexact, s1_inexact_q, out_inexact_q;
`endif

  fp_round_core #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_core (
    .data_i   (bus.in_data),
    .mode_i   (bus.in_mode),
    .sign_o   (c_sign),
    .mag_o    (c_mag),
    .addend_o (c_add)
`ifdef FP_ROUND_INEXACT_EN
    , .inexact_o (c_inexact)
`endif
  );

  // Whole pipeline moves together whenever the output slot is free or draining.
  assign adv          = ~out_valid_q | bus.out_ready;
  assign bus.in_ready = adv;

  // Mantissa carry ripples into the exponent naturally.
  always_comb begin
    out_data_d = {s1_sign_q, s1_mag_q + s1_add_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_mag_q    <= '0;
      s1_add_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (adv) begin
      s1_valid_q  <= bus.in_valid;
      s1_sign_q   <= c_sign;
      s1_mag_q    <= c_mag;
      s1_add_q    <= c_add;
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) out_data_q <= out_data_d;
    end
  end

`ifdef FP_ROUND_INEXACT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_inexact_q  <= 1'b0;
      out_inexact_q <= 1'b0;
    end else if (adv) begin
      s1_inexact_q <= c_inexact;
      if (s1_valid_q) out_inexact_q <= s1_inexact_q;
    end
  end

  assign bus.out_inexact = out_inexact_q;
`endif

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_fp_round_pipe.sv
// Bench for fp_round_pipe: binary32 and 16-bit (5/10) instances, arithmetic reference model.
// Honours FP_ROUND_INEXACT_EN when defined.
module tb_fp_round_pipe;
  import fp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   rx_a = 0;
  int   rx_b = 0;
  logic [64:0] qa[$];
  logic [64:0] qb[$];

  always #5 clk = ~clk;

  fp_round_pipe_if #(.EXP_W(8), .MAN_W(23)) ia ();
  fp_round_pipe_if #(.EXP_W(5), .MAN_W(10)) ib ();

  fp_round_pipe #(.EXP_W(8), .MAN_W(23)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  fp_round_pipe #(.EXP_W(5), .MAN_W(10)) dut_b (.clk(clk), .rst(rst), .bus(ib));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Value view: integer part and remainder of |x| scaled by 2^k, then re-encode.
  function automatic logic [64:0] model(input logic [63:0] x, input logic [1:0] mode,
                                        input int ew, input int mw);
    longint unsigned bias, ex, m, sig, q, rem, half, res;
    bit s, inc;
    int e, k, p;
    bias = (64'd1 << (ew - 1)) - 64'd1;
    ex   = (x >> mw) & ((64'd1 << ew) - 64'd1);
    m    = x & ((64'd1 << mw) - 64'd1);
    s    = ((x >> (ew + mw)) & 64'd1) != 64'd0;
    if (ex == (64'd1 << ew) - 64'd1 || (ex == 0 && m == 0)) return {1'b0, x};
    e = int'(ex) - int'(bias);
    if (e >= mw) return {1'b0, x};
    sig = (ex == 0) ? m : (m | (64'd1 << mw));
    if (e < -2) e = -2;  // any magnitude below 0.5 rounds the same way
    k    = mw - e;
    q    = sig >> k;
    rem  = sig & ((64'd1 << k) - 64'd1);
    half = 64'd1 << (k - 1);
    case (mode)
      RND_TRUNC: inc = 1'b0;
      RND_FLOOR: inc = s && rem != 0;
      RND_CEIL:  inc = !s && rem != 0;
      default:   inc = (rem > half) || (rem == half && (q & 64'd1) != 0);
    endcase
    q   = q + 64'(inc);
    res = s ? (64'd1 << (ew + mw)) : 64'd0;
    if (q != 0) begin
      p = 0;
      for (int i = 0; i < 63; i++) if (((q >> i) & 64'd1) != 0) p = i;
      res = res | ((64'(p) + bias) << mw) | ((q << (mw - p)) & ((64'd1 << mw) - 64'd1));
    end
    return {rem != 0, res};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      qa.delete();
    end else begin
      if (ia.out_valid) begin
        chk("a_in_ready_stall", 64'(ia.in_ready), 64'(ia.out_ready));
        if (qa.size() == 0) chk("a_spurious_out_valid", 64'(1), 64'(0));
        else begin
          chk("a_out_data", 64'(ia.out_data), qa[0][63:0]);
`ifdef FP_ROUND_INEXACT_EN
          chk("a_out_inexact", 64'(ia.out_inexact), 64'(qa[0][64]));
`endif
          if (ia.out_ready) begin void'(qa.pop_front()); rx_a++; end
        end
      end else chk("a_in_ready_idle", 64'(ia.in_ready), 64'(1));
      if (ia.in_valid && ia.in_ready) qa.push_back(model(64'(ia.in_data), ia.in_mode, 8, 23));
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      qb.delete();
    end else begin
      if (ib.out_valid) begin
        chk("b_in_ready_stall", 64'(ib.in_ready), 64'(ib.out_ready));
        if (qb.size() == 0) chk("b_spurious_out_valid", 64'(1), 64'(0));
        else begin
          chk("b_out_data", 64'(ib.out_data), qb[0][63:0]);
`ifdef FP_ROUND_INEXACT_EN
          chk("b_out_inexact", 64'(ib.out_inexact), 64'(qb[0][64]));
`endif
          if (ib.out_ready) begin void'(qb.pop_front()); rx_b++; end
        end
      end
      if (ib.in_valid && ib.in_ready) qb.push_back(model(64'(ib.in_data), ib.in_mode, 5, 10));
    end
  end

  task automatic send_a(input logic [31:0] d, input logic [1:0] m);
    int t = 0;
    ia.in_valid = 1'b1; ia.in_data = d; ia.in_mode = m;
    @(negedge clk);
    while (!ia.in_ready && t < 50) begin @(negedge clk); t++; end
    if (!ia.in_ready) chk("a_accept_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
  endtask

  task automatic send_b(input logic [15:0] d, input logic [1:0] m);
    int t = 0;
    ib.in_valid = 1'b1; ib.in_data = d; ib.in_mode = m;
    @(negedge clk);
    while (!ib.in_ready && t < 50) begin @(negedge clk); t++; end
    if (!ib.in_ready) chk("b_accept_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
  endtask

  task automatic vec_a(input logic [31:0] d, input logic [1:0] m, input logic [31:0] r,
                       input logic x);
    logic [64:0] mv;
    mv = model(64'(d), m, 8, 23);
    chk("a_model_pin_data", mv[63:0], 64'(r));
    chk("a_model_pin_inexact", 64'(mv[64]), 64'(x));
    send_a(d, m);
  endtask

  task automatic vec_b(input logic [15:0] d, input logic [1:0] m, input logic [15:0] r,
                       input logic x);
    logic [64:0] mv;
    mv = model(64'(d), m, 5, 10);
    chk("b_model_pin_data", mv[63:0], 64'(r));
    chk("b_model_pin_inexact", 64'(mv[64]), 64'(x));
    send_b(d, m);
  endtask

  task automatic drain();
    ia.in_valid = 1'b0; ib.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("a_queue_drained", 64'(qa.size()), 64'(0));
    chk("b_queue_drained", 64'(qb.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rx0;
    ia.in_valid = 0; ia.in_data = '0; ia.in_mode = '0; ia.out_ready = 1;
    ib.in_valid = 0; ib.in_data = '0; ib.in_mode = '0; ib.out_ready = 1;
    #1;
    chk("rst_a_out_valid", 64'(ia.out_valid), 64'(0));
    chk("rst_a_out_data", 64'(ia.out_data), 64'(0));
    chk("rst_b_out_valid", 64'(ib.out_valid), 64'(0));
`ifdef FP_ROUND_INEXACT_EN
    chk("rst_a_out_inexact", 64'(ia.out_inexact), 64'(0));
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_a_in_ready", 64'(ia.in_ready), 64'(1));

    vec_a(32'h4015FC65, RND_FLOOR, 32'h40000000, 1'b1);
    vec_a(32'hC015FC65, RND_FLOOR, 32'hC0400000, 1'b1);
    vec_a(32'hBF0F5C29, RND_FLOOR, 32'hBF800000, 1'b1);
    vec_a(32'h3F0F5C29, RND_FLOOR, 32'h00000000, 1'b1);
    vec_a(32'h5306BBF0, RND_FLOOR, 32'h5306BBF0, 1'b0);
    vec_a(32'h4015FC65, RND_CEIL,  32'h40400000, 1'b1);
    vec_a(32'hBF0F5C29, RND_CEIL,  32'h80000000, 1'b1);
    vec_a(32'hC015FC65, RND_TRUNC, 32'hC0000000, 1'b1);
    vec_a(32'h40200000, RND_RNE,   32'h40000000, 1'b1);
    vec_a(32'h40600000, RND_RNE,   32'h40800000, 1'b1);
    vec_a(32'h3F000000, RND_RNE,   32'h00000000, 1'b1);
    vec_a(32'h3F0F5C29, RND_RNE,   32'h3F800000, 1'b1);
    vec_a(32'h3FC00000, RND_RNE,   32'h40000000, 1'b1);
    vec_a(32'h3F800000, RND_RNE,   32'h3F800000, 1'b0);
    vec_a(32'h4AFFFFFF, RND_CEIL,  32'h4B000000, 1'b1);
    vec_a(32'h4B7FFFFF, RND_FLOOR, 32'h4B7FFFFF, 1'b0);
    vec_a(32'h00000001, RND_CEIL,  32'h3F800000, 1'b1);
    vec_a(32'h80000001, RND_FLOOR, 32'hBF800000, 1'b1);
    for (int m = 0; m < 4; m++) begin
      vec_a(32'h7FC00000, 2'(m), 32'h7FC00000, 1'b0);
      vec_a(32'hFF800000, 2'(m), 32'hFF800000, 1'b0);
      vec_a(32'h80000000, 2'(m), 32'h80000000, 1'b0);
    end
    drain();

    rx0 = rx_a;
    fork
      begin
        for (int i = 0; i < 5; i++) send_a(32'h40600000 + 32'(i) * 32'h00100000, 2'(i % 4));
        ia.in_valid = 1'b0;
      end
      begin
        int t = 0;
        @(posedge clk); #1;
        while (!ia.out_valid && t < 20) begin @(posedge clk); #1; t++; end
        if (!ia.out_valid) chk("bp_first_out_timeout", 64'(0), 64'(1));
        ia.out_ready = 1'b0;
        #4 chk("bp_in_ready_low", 64'(ia.in_ready), 64'(0));
        repeat (3) @(posedge clk);
        #1 ia.out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_result_count", 64'(rx_a - rx0), 64'(5));

    vec_b(16'h4A00, RND_FLOOR, 16'h4A00, 1'b0);
    vec_b(16'h4940, RND_RNE,   16'h4900, 1'b1);
    vec_b(16'h4940, RND_CEIL,  16'h4980, 1'b1);
    vec_b(16'h4940, RND_TRUNC, 16'h4900, 1'b1);
    vec_b(16'hC940, RND_FLOOR, 16'hC980, 1'b1);
    vec_b(16'h3800, RND_RNE,   16'h0000, 1'b1);
    vec_b(16'h3A00, RND_RNE,   16'h3C00, 1'b1);
    vec_b(16'h7C00, RND_CEIL,  16'h7C00, 1'b0);
    drain();

    // Two items in flight on both instances, output stalled, then reset mid-cycle.
    ia.out_ready = 0; ib.out_ready = 0;
    ia.in_valid = 1; ia.in_data = 32'h40600000; ia.in_mode = RND_RNE;
    ib.in_valid = 1; ib.in_data = 16'h4940;     ib.in_mode = RND_RNE;
    @(posedge clk); #1;
    ia.in_data = 32'h4015FC65; ib.in_data = 16'h4A00;
    @(posedge clk); #1;
    ia.in_valid = 0; ib.in_valid = 0;
    chk("inflight_a_latency_valid", 64'(ia.out_valid), 64'(1));
    chk("inflight_b_latency_valid", 64'(ib.out_valid), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_a_out_valid", 64'(ia.out_valid), 64'(0));
    chk("async_rst_a_out_data", 64'(ia.out_data), 64'(0));
    chk("async_rst_b_out_valid", 64'(ib.out_valid), 64'(0));
    chk("async_rst_b_out_data", 64'(ib.out_data), 64'(0));
`ifdef FP_ROUND_INEXACT_EN
    chk("async_rst_a_out_inexact", 64'(ia.out_inexact), 64'(0));
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    ia.out_ready = 1; ib.out_ready = 1;
    chk("post_rst_a_in_ready", 64'(ia.in_ready), 64'(1));
    chk("post_rst_b_in_ready", 64'(ib.in_ready), 64'(1));
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("post_rst_no_stale", 64'(ia.out_valid | ib.out_valid), 64'(0));
    end

    vec_b(16'h4940, RND_RNE, 16'h4900, 1'b1);
    vec_a(32'hC015FC65, RND_CEIL, 32'hC0000000, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fp_round_pipe.md
# fp_round_pipe

Pipelined, parametrised IEEE-754-style floating-point round-to-integral unit for the arithmetic datapath. It succeeds the combinational floor block with four selectable rounding modes (truncate, floor, ceil, round-half-even) chosen per transaction. It supports configurable exponent and mantissa widths and has a valid/ready streaming interface with full backpressure. It sits between the FP operand buffers and downstream FP converters/accumulators.

## Interface
- `EXP_W`, default 8: exponent field width (≥ 3).
- `MAN_W`, default 23: stored mantissa width (≥ 2).
- Derived `W = 1+EXP_W+MAN_W`, `BIAS = 2^(EXP_W-1)-1`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: input transaction present.
- `in_ready` out 1: unit accepts input this cycle.
- `in_data` in W: {sign, exp, man} operand.
- `in_mode` in 2: 00 trunc, 01 floor, 10 ceil, 11 round-half-even (RNE).
- `out_valid` out 1: result present.
- `out_ready` in 1: downstream accepts result.
- `out_data` out W: rounded result.
- `out_inexact` out 1: result differs from input. Present only with `FP_ROUND_INEXACT_EN`.

## Operation
- Decode: `s`, `E`, `M`; unbiased `e = E - BIAS`.
- `E` all ones (Inf/NaN): pass through bit-exact.
- `e ≥ MAN_W`: already integral; pass through.
- `E == 0` with `M == 0` (±0): pass through. Subnormals are treated as `e < 0`.
- `e < 0` (0 < |x| < 1):
  - trunc → ±0, sign kept.
  - floor → +0 if s=0, -1.0 if s=1.
  - ceil → +1.0 if s=0, -0 if s=1.
  - RNE → ±1.0 if e = -1 and M ≠ 0 (|x| > 0.5); otherwise ±0. Exactly 0.5 → ±0.
  - ±1.0 is encoded as {s, BIAS, 0}.
- `0 ≤ e < MAN_W`:
  - `k = MAN_W - e` fraction bits; `mask = 2^k - 1`; `frac = M & mask`.
  - `half = M[k-1]`; `sticky = |(M & (mask>>1))`; `lsb = M[k]` (implicit 1 when k = MAN_W).
  - Increment decision:
    - trunc: never.
    - floor: `s & (frac≠0)`.
    - ceil: `!s & (frac≠0)`.
    - RNE: `half & (sticky | lsb)`.
  - Result = `{s, ({E, M & ~mask}) + (inc << k)}`. Carry out of the mantissa propagates into the exponent; this cannot reach all-ones.
- Sign is always preserved (floor of -0.3 → -1.0; ceil of -0.3 → -0).
- Inexact: set for finite non-zero inputs with frac ≠ 0, and for every `e < 0` non-zero case. Clear otherwise, including NaN/Inf.

## Timing
- Two register stages:
  - S1: classify, mask, increment decision.
  - S2: add and result mux.
- Latency: 2 cycles from accepted input to `out_valid`.
- Throughput: 1 per cycle.
- Global pipeline enable `adv = !out_valid | out_ready`; `in_ready = adv`.
  - Stages shift only when `adv` = 1.
  - Bubbles propagate as invalid slots.
- Input is accepted when `in_valid & in_ready`.
- While `out_valid & !out_ready`: `out_data`, `out_valid` (and `out_inexact`) are held stable and no input is accepted.
- `in_mode` is sampled with `in_data` and carried per transaction. Mode changes between back-to-back items take effect for that item only.
- Reset (at any time, including mid-stream):
  - All stage valids → 0; `out_valid` = 0; `out_data` = 0; `out_inexact` = 0.
  - `in_ready` = 1 on the first cycle after reset deasserts.
  - In-flight items are discarded.

## Configuration
- `FP_ROUND_INEXACT_EN` defined: the inexact flag is computed in S1, pipelined with the data, and driven on `out_inexact`.
- Not defined: the port and its logic are absent. Data path and timing are identical in both builds.

## Structure
- Shared package `fp_pkg`:
  - mode encoding constants `RND_TRUNC`, `RND_FLOOR`, `RND_CEIL`, `RND_RNE`.
  - field-extraction and BIAS helper functions parametrised by EXP_W/MAN_W.
- One sub-module, `fp_round_core`: combinational classify/increment-decision logic instantiated in S1.
- The top level holds the handshake, pipeline registers and S2 adder.

## Test plan
- Default widths, mode floor: 0x4015FC65 → 0x40000000; 0xC015FC65 → 0xC0400000; 0xBF0F5C29 → 0xBF800000; 0x3F0F5C29 → 0x00000000; 0x5306BBF0 → 0x5306BBF0.
- Mode ceil: 0x4015FC65 → 0x40400000; 0xBF0F5C29 → 0x80000000. Mode trunc: 0xC015FC65 → 0xC0000000.
- Mode RNE: 0x40200000 → 0x40000000; 0x40600000 → 0x40800000; 0x3F000000 → 0x00000000; 0x3F0F5C29 → 0x3F800000. With `FP_ROUND_INEXACT_EN`, inexact = 1 on each.
- Specials in all modes: 0x7FC00000 → 0x7FC00000; 0xFF800000 → 0xFF800000; 0x80000000 → 0x80000000; inexact = 0.
- Backpressure: stream 5 items back-to-back and hold `out_ready` = 0 for 3 cycles after the first `out_valid`. Required: `in_ready` = 0 while stalled, `out_data` stable, all 5 results in order with none lost or duplicated. Alternate modes per item.
- Reset asserted with 2 items in flight: `out_valid` drops asynchronously; `out_data` = 0; no stale output after release. Repeat at EXP_W = 5, MAN_W = 10: 0x4A00 (12.0) → 0x4A00; 0x4940 (10.5) under RNE → 0x4900.
